// File: rtl/tsqr_feed_pkg.sv
// Shared types and defaults for the TSQR tile feeder.
package tsqr_feed_pkg;

    localparam int ROWS_DEF = 4;
    localparam int ST_DEF   = 4;
    localparam int DW_DEF   = 32;

    // Sequencer states: wait for a job, pick the next core, stream one tile, signal completion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEL    = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } feed_state_e;

    typedef logic [DW_DEF-1:0]        float_t;
    typedef logic [ST_DEF*DW_DEF-1:0] row_t;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tsqr_fi_credit.sv
// Two-bank sticky finish credit for one core, with the expected-bank pointer.
module tsqr_fi_credit (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic set0,
    input  logic set1,
    input  logic consume,
    output logic avail
);

    logic [1:0] credit_r;
    logic       exp_bank_r;

    // Latch finish pulses (a new pulse beats a same-cycle consume) and flip the expected bank on use.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_r   <= 2'b00;
            exp_bank_r <= 1'b0;
        end else if (clr) begin
            credit_r   <= 2'b00;
            exp_bank_r <= 1'b0;
        end else begin
            credit_r[0] <= set0 | (credit_r[0] & ~(consume & ~exp_bank_r));
            credit_r[1] <= set1 | (credit_r[1] & ~(consume &  exp_bank_r));
            if (consume) begin
                exp_bank_r <= ~exp_bank_r;
            end
        end
    end

    assign avail = credit_r[exp_bank_r];

endmodule

// File: rtl/tsqr_tile_feeder.sv
// Round-robin tile sequencer feeding one shared row stream to CORE_NO TSQR cores.
module tsqr_tile_feeder
    import tsqr_feed_pkg::*;
#(
    parameter int CORE_NO       = 1,
    parameter int ST            = ST_DEF,
    parameter int DW            = DW_DEF,
    parameter int ROWS          = ROWS_DEF,
    parameter int PREFILL_TILES = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    tile_no,
    input  logic                    src_valid,
    output logic                    src_ready,
    input  logic [ST*DW-1:0]        src_ug,
    input  logic [ST*DW-1:0]        src_pg,
    input  logic [DW-1:0]           src_e_ug,
    input  logic [DW-1:0]           src_e_pg,
    input  logic [DW-1:0]           src_e_upg,
    output logic [CORE_NO*ST*DW-1:0] ug_i,
    output logic [CORE_NO*ST*DW-1:0] pg_i,
    output logic [CORE_NO*DW-1:0]   e_ug,
    output logic [CORE_NO*DW-1:0]   e_pg,
    output logic [CORE_NO*DW-1:0]   e_upg,
    output logic [CORE_NO-1:0]      ug_ready,
    output logic [CORE_NO-1:0]      pg_ready,
    output logic [CORE_NO-1:0]      e_ug_ready,
    output logic [CORE_NO-1:0]      e_pg_ready,
    output logic [CORE_NO-1:0]      e_upg_ready,
    input  logic [CORE_NO-1:0]      mem0_fi,
    input  logic [CORE_NO-1:0]      mem1_fi,
    output logic                    busy,
    output logic                    done
);

    localparam int RW  = ST * DW;
    localparam int CIW = idx_width(CORE_NO);
    localparam int BIW = idx_width(ROWS);

    feed_state_e            state_r;
    feed_state_e            state_s;
    logic [CNT_WIDTH-1:0]   tile_total_r;
    logic [CNT_WIDTH-1:0]   tile_idx_r;
    logic [BIW-1:0]         row_cnt_r;
    logic [CIW-1:0]         core_sel_r;
    logic [CNT_WIDTH-1:0]   core_tiles_r [CORE_NO];

    logic [CORE_NO-1:0]     consume_s;
    logic [CORE_NO-1:0]     avail_s;
    logic                   clr_s;
    logic                   accept_s;
    logic                   last_beat_s;
    logic                   prefill_s;

    logic [CORE_NO*RW-1:0]  ug_r;
    logic [CORE_NO*RW-1:0]  pg_r;
    logic [CORE_NO*DW-1:0]  e_ug_r;
    logic [CORE_NO*DW-1:0]  e_pg_r;
    logic [CORE_NO*DW-1:0]  e_upg_r;
    logic [CORE_NO-1:0]     row_stb_r;
    logic [CORE_NO-1:0]     e_stb_r;
    logic                   busy_r;
    logic                   done_r;

    assign clr_s       = (state_r == IDLE) && start;
    assign accept_s    = src_valid && (state_r == STREAM);
    assign last_beat_s = accept_s && (row_cnt_r == BIW'(ROWS - 1));
    assign prefill_s   = core_tiles_r[core_sel_r] < CNT_WIDTH'(PREFILL_TILES);

    for (genvar g = 0; g < CORE_NO; g++) begin : g_credit
        tsqr_fi_credit u_credit (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr_s),
            .set0    (mem0_fi[g]),
            .set1    (mem1_fi[g]),
            .consume (consume_s[g]),
            .avail   (avail_s[g])
        );
    end

    // Next-state logic and credit consumption for the selected core.
    always_comb begin
        state_s   = state_r;
        consume_s = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (tile_no == '0) begin
                        state_s = FIN;
                    end else begin
                        state_s = SEL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEL: begin
                if (prefill_s) begin
                    state_s = STREAM;
                end else if (avail_s[core_sel_r]) begin
                    state_s               = STREAM;
                    consume_s[core_sel_r] = 1'b1;
                end else begin
                    state_s = SEL;
                end
            end
            STREAM: begin
                if (last_beat_s) begin
                    if (tile_idx_r == tile_total_r - CNT_WIDTH'(1)) begin
                        state_s = FIN;
                    end else begin
                        state_s = SEL;
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus tile, row, core-rotation and per-core tile counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            tile_total_r <= '0;
            tile_idx_r   <= '0;
            row_cnt_r    <= '0;
            core_sel_r   <= '0;
            for (int c = 0; c < CORE_NO; c++) begin
                core_tiles_r[c] <= '0;
            end
        end else begin
            state_r <= state_s;
            if (clr_s) begin
                tile_total_r <= tile_no;
                tile_idx_r   <= '0;
                row_cnt_r    <= '0;
                core_sel_r   <= '0;
                for (int c = 0; c < CORE_NO; c++) begin
                    core_tiles_r[c] <= '0;
                end
            end else if (last_beat_s) begin
                row_cnt_r                <= '0;
                tile_idx_r               <= tile_idx_r + CNT_WIDTH'(1);
                core_tiles_r[core_sel_r] <= core_tiles_r[core_sel_r] + CNT_WIDTH'(1);
                if (core_sel_r == CIW'(CORE_NO - 1)) begin
                    core_sel_r <= '0;
                end else begin
                    core_sel_r <= core_sel_r + CIW'(1);
                end
            end else if (accept_s) begin
                row_cnt_r <= row_cnt_r + BIW'(1);
            end
        end
    end

    // Registered core-side outputs: route an accepted beat to its core's slice and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ug_r      <= '0;
            pg_r      <= '0;
            e_ug_r    <= '0;
            e_pg_r    <= '0;
            e_upg_r   <= '0;
            row_stb_r <= '0;
            e_stb_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            for (int c = 0; c < CORE_NO; c++) begin
                if (accept_s && (core_sel_r == CIW'(c))) begin
                    ug_r[c*RW +: RW]    <= src_ug;
                    pg_r[c*RW +: RW]    <= src_pg;
                    e_ug_r[c*DW +: DW]  <= src_e_ug;
                    e_pg_r[c*DW +: DW]  <= src_e_pg;
                    e_upg_r[c*DW +: DW] <= src_e_upg;
                    row_stb_r[c]        <= 1'b1;
                    e_stb_r[c]          <= prefill_s;
                end else begin
                    row_stb_r[c] <= 1'b0;
                    e_stb_r[c]   <= 1'b0;
                end
            end
            busy_r <= (state_s == SEL) || (state_s == STREAM);
            done_r <= (state_r == FIN);
        end
    end

    assign src_ready   = (state_r == STREAM);
    assign ug_i        = ug_r;
    assign pg_i        = pg_r;
    assign e_ug        = e_ug_r;
    assign e_pg        = e_pg_r;
    assign e_upg       = e_upg_r;
    assign ug_ready    = row_stb_r;
    assign pg_ready    = row_stb_r;
    assign e_ug_ready  = e_stb_r;
    assign e_pg_ready  = e_stb_r;
    assign e_upg_ready = e_stb_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_tsqr_tile_feeder.sv
// Randomized bench for tsqr_tile_feeder with a job-level reference model.
module tb_tsqr_tile_feeder;

    localparam int CORE_NO = 2;
    localparam int ST      = 4;
    localparam int DW      = 32;
    localparam int ROWS    = 4;
    localparam int PREF    = 3;
    localparam int CW      = 16;
    localparam int RW      = ST * DW;
    localparam int OW      = CORE_NO * RW;
    localparam int SW      = CORE_NO * DW;

    logic               clk = 1'b0;
    logic               rst, start, src_valid, src_ready, busy, done;
    logic [CW-1:0]      tile_no;
    logic [RW-1:0]      src_ug, src_pg;
    logic [DW-1:0]      src_e_ug, src_e_pg, src_e_upg;
    logic [OW-1:0]      ug_i, pg_i;
    logic [SW-1:0]      e_ug, e_pg, e_upg;
    logic [CORE_NO-1:0] ug_ready, pg_ready, e_ug_ready, e_pg_ready, e_upg_ready;
    logic [CORE_NO-1:0] mem0_fi, mem1_fi;

    tsqr_tile_feeder #(
        .CORE_NO(CORE_NO), .ST(ST), .DW(DW), .ROWS(ROWS),
        .PREFILL_TILES(PREF), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tile_no(tile_no),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_ug(src_ug), .src_pg(src_pg),
        .src_e_ug(src_e_ug), .src_e_pg(src_e_pg), .src_e_upg(src_e_upg),
        .ug_i(ug_i), .pg_i(pg_i), .e_ug(e_ug), .e_pg(e_pg), .e_upg(e_upg),
        .ug_ready(ug_ready), .pg_ready(pg_ready),
        .e_ug_ready(e_ug_ready), .e_pg_ready(e_pg_ready), .e_upg_ready(e_upg_ready),
        .mem0_fi(mem0_fi), .mem1_fi(mem1_fi), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (job / tile / beat view) ----------------
    bit                 m_job, m_str, m_pend;
    int                 m_total, m_tile, m_beat;
    int                 m_cnt [CORE_NO];
    bit                 m_cred[CORE_NO][2];
    bit                 m_bank[CORE_NO];
    logic [OW-1:0]      x_ug, x_pg;
    logic [SW-1:0]      x_eug, x_epg, x_eupg;
    logic [CORE_NO-1:0] x_rowr, x_er;
    logic               x_busy, x_done, x_srdy;

    task automatic model_reset();
        m_job = 0; m_str = 0; m_pend = 0; m_total = 0; m_tile = 0; m_beat = 0;
        for (int k = 0; k < CORE_NO; k++) begin
            m_cnt[k] = 0; m_cred[k][0] = 0; m_cred[k][1] = 0; m_bank[k] = 0;
        end
        x_ug = '0; x_pg = '0; x_eug = '0; x_epg = '0; x_eupg = '0;
        x_rowr = '0; x_er = '0; x_busy = 0; x_done = 0; x_srdy = 0;
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        int c;
        bit idle;
        if (rst) begin
            model_reset();
            return;
        end
        idle   = !m_job && !m_pend;
        x_done = m_pend;
        m_pend = 0;
        x_rowr = '0;
        x_er   = '0;
        c      = m_tile % CORE_NO;
        if (idle && start) begin
            for (int k = 0; k < CORE_NO; k++) begin
                m_cnt[k] = 0; m_cred[k][0] = 0; m_cred[k][1] = 0; m_bank[k] = 0;
            end
            m_tile = 0; m_beat = 0; m_str = 0; m_total = int'(tile_no);
            if (tile_no == 0) m_pend = 1;
            else m_job = 1;
        end else begin
            if (m_job && !m_str) begin
                if (m_cnt[c] < PREF) begin
                    m_str = 1;
                end else if (m_cred[c][m_bank[c]]) begin
                    m_cred[c][m_bank[c]] = 0;
                    m_bank[c] = !m_bank[c];
                    m_str = 1;
                end
            end else if (m_job && m_str && src_valid) begin
                x_ug[c*RW +: RW]   = src_ug;
                x_pg[c*RW +: RW]   = src_pg;
                x_eug[c*DW +: DW]  = src_e_ug;
                x_epg[c*DW +: DW]  = src_e_pg;
                x_eupg[c*DW +: DW] = src_e_upg;
                x_rowr[c] = 1'b1;
                x_er[c]   = (m_cnt[c] < PREF);
                m_beat++;
                if (m_beat == ROWS) begin
                    m_beat = 0; m_cnt[c]++; m_tile++; m_str = 0;
                    if (m_tile == m_total) begin
                        m_job = 0; m_pend = 1;
                    end
                end
            end
            for (int k = 0; k < CORE_NO; k++) begin
                if (mem0_fi[k]) m_cred[k][0] = 1;
                if (mem1_fi[k]) m_cred[k][1] = 1;
            end
        end
        x_busy = m_job;
        x_srdy = m_job && m_str;
    endtask

    // Compare every output against the model on each falling edge, then step the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            check("ug_ready", ug_ready, x_rowr);
            check("pg_ready", pg_ready, x_rowr);
            check("e_ug_ready", e_ug_ready, x_er);
            check("e_pg_ready", e_pg_ready, x_er);
            check("e_upg_ready", e_upg_ready, x_er);
            check("ug_i", ug_i, x_ug);
            check("pg_i", pg_i, x_pg);
            check("e_ug", e_ug, x_eug);
            check("e_pg", e_pg, x_epg);
            check("e_upg", e_upg, x_eupg);
            check("busy", busy, x_busy);
            check("done", done, x_done);
            check("src_ready", src_ready, x_srdy);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    int cyc = 0, n_beats = 0, n_ebeats = 0, n_done = 0;
    int vmode = 0;   // 0: valid always, 1: toggling, 2: random
    int fi_pct = 0;  // per-cycle finish pulse probability (percent)

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (|ug_ready)   n_beats++;
        if (|e_ug_ready) n_ebeats++;
        if (done)        n_done++;
        start   = 1'b0;
        mem0_fi = '0;
        mem1_fi = '0;
        case (vmode)
            0:       src_valid = 1'b1;
            1:       src_valid = ~src_valid;
            default: src_valid = ($urandom_range(0, 3) != 0);
        endcase
        for (int i = 0; i < ST; i++) begin
            src_ug[i*DW +: DW] = $urandom();
            src_pg[i*DW +: DW] = $urandom();
        end
        src_e_ug = $urandom(); src_e_pg = $urandom(); src_e_upg = $urandom();
        if (fi_pct > 0) begin
            for (int k = 0; k < CORE_NO; k++) begin
                mem0_fi[k] = ($urandom_range(0, 99) < fi_pct);
                mem1_fi[k] = ($urandom_range(0, 99) < fi_pct);
            end
        end
    endtask

    task automatic wait_done(input int budget, output int at);
        int d;
        d  = n_done;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != d) begin
                at = cyc;
                break;
            end
        end
        n_cmp++;
        if (at < 0) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        int nb0, ne0, nd0, at, t32;
        logic [6:0] pat;
        int pn;
        rst = 1'b1; start = 1'b0; tile_no = '0; src_valid = 1'b0;
        src_ug = '0; src_pg = '0; src_e_ug = '0; src_e_pg = '0; src_e_upg = '0;
        mem0_fi = '0; mem1_fi = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {ug_ready, e_ug_ready}, 0);
        rst = 1'b0;
        tick();

        // Prefill, stall, wrong-core credit, then release.
        vmode = 0;
        nb0 = n_beats; ne0 = n_ebeats; nd0 = n_done;
        start = 1'b1; tile_no = 16'd8;
        repeat (50) tick();
        check("t1_prefill_beats", n_beats - nb0, 24);
        check("t1_prefill_ebeats", n_ebeats - ne0, 24);
        mem0_fi[1] = 1'b1;
        repeat (15) tick();
        check("t1_wrong_core_hold", n_beats - nb0, 24);
        mem0_fi[0] = 1'b1;
        wait_done(60, at);
        check("t1_total_beats", n_beats - nb0, 32);
        check("t1_total_ebeats", n_ebeats - ne0, 24);
        check("t1_done_count", n_done - nd0, 1);

        // Early credits; a repeated mem0 pulse must not release a bank-1 tile.
        nb0 = n_beats; nd0 = n_done;
        start = 1'b1; tile_no = 16'd10; cyc = 0; t32 = -1;
        for (int i = 0; i < 80 && t32 < 0; i++) begin
            tick();
            if (cyc == 13) mem0_fi[0] = 1'b1;
            if (cyc == 14) mem0_fi[1] = 1'b1;
            if (cyc == 35) mem0_fi[0] = 1'b1;
            if (n_beats - nb0 == 32) t32 = cyc;
        end
        check("t2_beat32_cycle", t32, 41);
        repeat (15) tick();
        check("t2_bank1_hold", n_beats - nb0, 32);
        mem1_fi[0] = 1'b1;
        repeat (20) tick();
        check("t2_core1_hold", n_beats - nb0, 36);
        mem1_fi[1] = 1'b1;
        wait_done(40, at);
        check("t2_total_beats", n_beats - nb0, 40);

        // Bubbles: toggling valid gives alternating strobes on core 0.
        vmode = 1; nd0 = n_done; pat = '0; pn = 0;
        start = 1'b1; tile_no = 16'd2;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((pn > 0 || ug_ready[0]) && pn < 7) begin
                pat = {pat[5:0], ug_ready[0]};
                pn++;
            end
        end
        check("t3_bubble_pattern", pat, 7'b1010101);
        check("t3_done_count", n_done - nd0, 1);

        // Zero-tile job and start while busy.
        vmode = 0; nb0 = n_beats; nd0 = n_done;
        start = 1'b1; tile_no = 16'd0; cyc = 0;
        wait_done(10, at);
        check("t4_zero_done_cycle", at, 2);
        check("t4_zero_no_beats", n_beats - nb0, 0);
        nd0 = n_done;
        start = 1'b1; tile_no = 16'd4;
        repeat (3) tick();
        start = 1'b1; tile_no = 16'd0;
        wait_done(40, at);
        repeat (5) tick();
        check("t4_busy_start_ignored", n_done - nd0, 1);
        check("t4_beats", n_beats - nb0, 16);

        // Reset mid-stream, then a fresh job with cleared credits.
        nd0 = n_done; nb0 = n_beats;
        start = 1'b1; tile_no = 16'd8;
        for (int i = 0; i < 40 && (n_beats - nb0) < 6; i++) begin
            tick();
            if (i == 2) mem0_fi = '1;
        end
        rst = 1'b1;
        tick();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_strobes", ug_ready, 0);
        rst = 1'b0;
        repeat (10) tick();
        check("t5_no_done", n_done - nd0, 0);
        nb0 = n_beats;
        start = 1'b1; tile_no = 16'd8;
        repeat (50) tick();
        check("t5_replay_stall", n_beats - nb0, 24);
        mem0_fi = '1;
        wait_done(60, at);
        check("t5_replay_beats", n_beats - nb0, 32);

        // Randomized jobs with random valid, finish pulses, stray starts and resets.
        vmode = 2; fi_pct = 10;
        for (int j = 0; j < 12; j++) begin
            start = 1'b1; tile_no = CW'($urandom_range(0, 9));
            for (int i = 0; i < int'($urandom_range(5, 40)); i++) begin
                tick();
                if ($urandom_range(0, 15) == 0) begin
                    start = 1'b1; tile_no = CW'($urandom_range(0, 5));
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                tick();
            end else if (busy) begin
                wait_done(800, at);
            end
            repeat (3) tick();
        end
        vmode = 0; fi_pct = 0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
